n1_sarb: RTL and testbench

- Stack bus arbiter directly downstream of the two intermediate/lower stack blocks.
- Merges the pipelined Wishbone initiator ports of the parameter stack (PS) and return stack (RS) onto the single stack bus towards RAM.
- Grants exactly one initiator at a time and holds the grant for that initiator's entire bus cycle.
- Routes target responses back to the granted initiator only.

---
 rtl/n1_sarb.sv | 160 ++++++++++++++++
 tb/tb_n1_sarb.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/n1_sarb.sv
// n1_sarb: stack bus arbiter merging the PS and RS pipelined Wishbone initiators onto one RAM bus.
// Optional macro SARB_RR_EN selects a round-robin tie-break; without it, RS always wins ties.
module n1_sarb #(
    parameter int SP_WIDTH = 12
) (
    input  logic                clk_i,
    input  logic                sync_rst_i,
    input  logic                ps2sarb_cyc_i,
    input  logic                ps2sarb_stb_i,
    input  logic                ps2sarb_we_i,
    input  logic [SP_WIDTH-1:0] ps2sarb_adr_i,
    input  logic [15:0]         ps2sarb_dat_i,
    output logic                sarb2ps_ack_o,
    output logic                sarb2ps_err_o,
    output logic                sarb2ps_rty_o,
    output logic                sarb2ps_stall_o,
    output logic [15:0]         sarb2ps_dat_o,
    input  logic                rs2sarb_cyc_i,
    input  logic                rs2sarb_stb_i,
    input  logic                rs2sarb_we_i,
    input  logic [SP_WIDTH-1:0] rs2sarb_adr_i,
    input  logic [15:0]         rs2sarb_dat_i,
    output logic                sarb2rs_ack_o,
    output logic                sarb2rs_err_o,
    output logic                sarb2rs_rty_o,
    output logic                sarb2rs_stall_o,
    output logic [15:0]         sarb2rs_dat_o,
    output logic                sarb2sbus_cyc_o,
    output logic                sarb2sbus_stb_o,
    output logic                sarb2sbus_we_o,
    output logic [SP_WIDTH-1:0] sarb2sbus_adr_o,
    output logic [15:0]         sarb2sbus_dat_o,
    input  logic                sbus2sarb_ack_i,
    input  logic                sbus2sarb_err_i,
    input  logic                sbus2sarb_rty_i,
    input  logic                sbus2sarb_stall_i,
    input  logic [15:0]         sbus2sarb_dat_i,
    output logic [1:0]          prb_sarb_state_o
);

    typedef enum logic [1:0] {
        IDLE    = 2'b00,
        PS      = 2'b01,
        RS      = 2'b10,
        ILLEGAL = 2'b11
    } state_t;

    state_t state_q;
    state_t state_nxt;
    logic   gnt_ps;
    logic   gnt_rs;
    logic   tie_to_ps;

`ifdef SARB_RR_EN
    // High when RS held the most recent grant, so the next tie goes to PS.
    logic last_rs_q;

    always_ff @(posedge clk_i) begin
        if (sync_rst_i) begin
            last_rs_q <= 1'b1;
        end else if (state_q == IDLE && (gnt_ps || gnt_rs)) begin
            last_rs_q <= gnt_rs;
        end
    end

    assign tie_to_ps = last_rs_q;
`else
    assign tie_to_ps = 1'b0;
`endif

    always_ff @(posedge clk_i) begin
        if (sync_rst_i) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_nxt;
        end
    end

    // Grant is zero-latency in IDLE; reset kills it in the same cycle.
    always_comb begin
        gnt_ps    = 1'b0;
        gnt_rs    = 1'b0;
        state_nxt = state_q;
        if (!sync_rst_i) begin
            case (state_q)
                IDLE: begin
                    if (ps2sarb_cyc_i && rs2sarb_cyc_i) begin
                        gnt_ps = tie_to_ps;
                        gnt_rs = !tie_to_ps;
                    end else begin
                        gnt_ps = ps2sarb_cyc_i;
                        gnt_rs = rs2sarb_cyc_i;
                    end
                    if (gnt_ps) begin
                        state_nxt = PS;
                    end else if (gnt_rs) begin
                        state_nxt = RS;
                    end
                end
                PS: begin
                    gnt_ps = 1'b1;
                    if (!ps2sarb_cyc_i) begin
                        state_nxt = IDLE;
                    end
                end
                RS: begin
                    gnt_rs = 1'b1;
                    if (!rs2sarb_cyc_i) begin
                        state_nxt = IDLE;
                    end
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

    // Handshake: a request transfers when stb is high and stall is low; a
    // non-granted initiator sees stall equal to its own stb until granted.
    always_comb begin
        sarb2sbus_cyc_o = 1'b0;
        sarb2sbus_stb_o = 1'b0;
        sarb2sbus_we_o  = 1'b0;
        sarb2sbus_adr_o = '0;
        sarb2sbus_dat_o = '0;
        sarb2ps_ack_o   = 1'b0;
        sarb2ps_err_o   = 1'b0;
        sarb2ps_rty_o   = 1'b0;
        sarb2ps_stall_o = ps2sarb_stb_i;
        sarb2rs_ack_o   = 1'b0;
        sarb2rs_err_o   = 1'b0;
        sarb2rs_rty_o   = 1'b0;
        sarb2rs_stall_o = rs2sarb_stb_i;
        if (gnt_ps) begin
            sarb2sbus_cyc_o = ps2sarb_cyc_i;
            sarb2sbus_stb_o = ps2sarb_stb_i;
            sarb2sbus_we_o  = ps2sarb_we_i;
            sarb2sbus_adr_o = ps2sarb_adr_i;
            sarb2sbus_dat_o = ps2sarb_dat_i;
            sarb2ps_ack_o   = sbus2sarb_ack_i;
            sarb2ps_err_o   = sbus2sarb_err_i;
            sarb2ps_rty_o   = sbus2sarb_rty_i;
            sarb2ps_stall_o = sbus2sarb_stall_i;
        end else if (gnt_rs) begin
            sarb2sbus_cyc_o = rs2sarb_cyc_i;
            sarb2sbus_stb_o = rs2sarb_stb_i;
            sarb2sbus_we_o  = rs2sarb_we_i;
            sarb2sbus_adr_o = rs2sarb_adr_i;
            sarb2sbus_dat_o = rs2sarb_dat_i;
            sarb2rs_ack_o   = sbus2sarb_ack_i;
            sarb2rs_err_o   = sbus2sarb_err_i;
            sarb2rs_rty_o   = sbus2sarb_rty_i;
            sarb2rs_stall_o = sbus2sarb_stall_i;
        end
    end

    assign sarb2ps_dat_o    = sbus2sarb_dat_i;
    assign sarb2rs_dat_o    = sbus2sarb_dat_i;
    assign prb_sarb_state_o = sync_rst_i ? 2'b00 : state_q;

endmodule

// File: tb/tb_n1_sarb.sv
// Directed self-checking bench for n1_sarb; expectations follow SARB_RR_EN when defined.
module tb_n1_sarb;

    logic        clk_i = 1'b0;
    logic        sync_rst_i;
    logic        ps_cyc, ps_stb, ps_we;
    logic [11:0] ps_adr;
    logic [15:0] ps_dat;
    logic        ps_ack, ps_err, ps_rty, ps_stall;
    logic [15:0] ps_rdat;
    logic        rs_cyc, rs_stb, rs_we;
    logic [11:0] rs_adr;
    logic [15:0] rs_dat;
    logic        rs_ack, rs_err, rs_rty, rs_stall;
    logic [15:0] rs_rdat;
    logic        sb_cyc, sb_stb, sb_we;
    logic [11:0] sb_adr;
    logic [15:0] sb_wdat;
    logic        sb_ack, sb_err, sb_rty, sb_stall;
    logic [15:0] sb_rdat;
    logic [1:0]  prb;

    int   checks = 0;
    int   errors = 0;
    logic last_ps;

    always #5 clk_i = ~clk_i;

    n1_sarb #(.SP_WIDTH(12)) dut (
        .clk_i(clk_i), .sync_rst_i(sync_rst_i),
        .ps2sarb_cyc_i(ps_cyc), .ps2sarb_stb_i(ps_stb), .ps2sarb_we_i(ps_we),
        .ps2sarb_adr_i(ps_adr), .ps2sarb_dat_i(ps_dat),
        .sarb2ps_ack_o(ps_ack), .sarb2ps_err_o(ps_err), .sarb2ps_rty_o(ps_rty),
        .sarb2ps_stall_o(ps_stall), .sarb2ps_dat_o(ps_rdat),
        .rs2sarb_cyc_i(rs_cyc), .rs2sarb_stb_i(rs_stb), .rs2sarb_we_i(rs_we),
        .rs2sarb_adr_i(rs_adr), .rs2sarb_dat_i(rs_dat),
        .sarb2rs_ack_o(rs_ack), .sarb2rs_err_o(rs_err), .sarb2rs_rty_o(rs_rty),
        .sarb2rs_stall_o(rs_stall), .sarb2rs_dat_o(rs_rdat),
        .sarb2sbus_cyc_o(sb_cyc), .sarb2sbus_stb_o(sb_stb), .sarb2sbus_we_o(sb_we),
        .sarb2sbus_adr_o(sb_adr), .sarb2sbus_dat_o(sb_wdat),
        .sbus2sarb_ack_i(sb_ack), .sbus2sarb_err_i(sb_err), .sbus2sarb_rty_i(sb_rty),
        .sbus2sarb_stall_i(sb_stall), .sbus2sarb_dat_i(sb_rdat),
        .prb_sarb_state_o(prb)
    );

    task tick;
        @(posedge clk_i);
        #1;
    endtask

    task settle;
        #2;
    endtask

    task clear_inputs;
        ps_cyc = 0; ps_stb = 0; ps_we = 0; ps_adr = '0; ps_dat = '0;
        rs_cyc = 0; rs_stb = 0; rs_we = 0; rs_adr = '0; rs_dat = '0;
        sb_ack = 0; sb_err = 0; sb_rty = 0; sb_stall = 0; sb_rdat = '0;
    endtask

    task go_idle;
        clear_inputs();
        tick();
        tick();
    endtask

    task test_reset;
        logic [11:0] exp_adr;
        clear_inputs();
        sync_rst_i = 1;
        ps_cyc = 1; ps_stb = 1; ps_adr = 12'h111;
        rs_cyc = 1; rs_stb = 1; rs_adr = 12'h222;
        sb_ack = 1;
        tick();
        tick();
        settle();
        checks++; if (sb_cyc !== 1'b0) begin errors++; $display("FAIL rst_sbus_cyc got %b exp 0", sb_cyc); end
        checks++; if (sb_stb !== 1'b0) begin errors++; $display("FAIL rst_sbus_stb got %b exp 0", sb_stb); end
        checks++; if (sb_adr !== 12'h000) begin errors++; $display("FAIL rst_sbus_adr got %h exp 000", sb_adr); end
        checks++; if (prb !== 2'b00) begin errors++; $display("FAIL rst_state got %b exp 00", prb); end
        checks++; if ({ps_ack, rs_ack} !== 2'b00) begin errors++; $display("FAIL rst_ack got %b exp 00", {ps_ack, rs_ack}); end
        checks++; if (ps_stall !== 1'b1) begin errors++; $display("FAIL rst_ps_stall got %b exp 1", ps_stall); end
        sync_rst_i = 0;
        sb_ack = 0;
        settle();
`ifdef SARB_RR_EN
        exp_adr = 12'h111;
        last_ps = 1;
`else
        exp_adr = 12'h222;
        last_ps = 0;
`endif
        checks++; if (sb_cyc !== 1'b1) begin errors++; $display("FAIL rst_first_grant_cyc got %b exp 1", sb_cyc); end
        checks++; if (sb_adr !== exp_adr) begin errors++; $display("FAIL rst_first_grant_adr got %h exp %h", sb_adr, exp_adr); end
        go_idle();
    endtask

    task test_ps_write;
        ps_cyc = 1; ps_stb = 1; ps_we = 1; ps_adr = 12'hFFF; ps_dat = 16'hA5A5;
        settle();
        checks++; if ({sb_cyc, sb_stb, sb_we} !== 3'b111) begin errors++; $display("FAIL psw_ctl got %b exp 111", {sb_cyc, sb_stb, sb_we}); end
        checks++; if (sb_adr !== 12'hFFF) begin errors++; $display("FAIL psw_adr got %h exp fff", sb_adr); end
        checks++; if (sb_wdat !== 16'hA5A5) begin errors++; $display("FAIL psw_dat got %h exp a5a5", sb_wdat); end
        checks++; if (prb !== 2'b00) begin errors++; $display("FAIL psw_state0 got %b exp 00", prb); end
        tick();
        ps_stb = 0; sb_ack = 1;
        settle();
        checks++; if (ps_ack !== 1'b1) begin errors++; $display("FAIL psw_ack got %b exp 1", ps_ack); end
        checks++; if (rs_ack !== 1'b0) begin errors++; $display("FAIL psw_rs_ack got %b exp 0", rs_ack); end
        checks++; if (prb !== 2'b01) begin errors++; $display("FAIL psw_state1 got %b exp 01", prb); end
        tick();
        ps_cyc = 0; sb_ack = 0;
        settle();
        checks++; if (sb_cyc !== 1'b0) begin errors++; $display("FAIL psw_cyc_drop got %b exp 0", sb_cyc); end
        tick();
        settle();
        checks++; if (prb !== 2'b00) begin errors++; $display("FAIL psw_state2 got %b exp 00", prb); end
        last_ps = 1;
        go_idle();
    endtask

    task test_burst;
        ps_cyc = 1; ps_stb = 1; ps_adr = 12'h001;
        tick();
        rs_cyc = 1; rs_stb = 1; rs_adr = 12'h0C0;
        for (int i = 0; i < 3; i++) begin
            ps_stb = (i < 2); ps_adr = 12'(i + 2);
            sb_ack = 1; sb_rdat = 16'(16'h0100 + i);
            settle();
            checks++; if (rs_stall !== 1'b1) begin errors++; $display("FAIL burst_rs_stall[%0d] got %b exp 1", i, rs_stall); end
            checks++; if (rs_ack !== 1'b0) begin errors++; $display("FAIL burst_rs_ack[%0d] got %b exp 0", i, rs_ack); end
            checks++; if (ps_ack !== 1'b1) begin errors++; $display("FAIL burst_ps_ack[%0d] got %b exp 1", i, ps_ack); end
            tick();
        end
        ps_cyc = 0; ps_stb = 0; sb_ack = 0;
        settle();
        checks++; if (sb_cyc !== 1'b0) begin errors++; $display("FAIL burst_gap_cyc got %b exp 0", sb_cyc); end
        checks++; if (rs_stall !== 1'b1) begin errors++; $display("FAIL burst_gap_stall got %b exp 1", rs_stall); end
        tick();
        settle();
        checks++; if (prb !== 2'b00) begin errors++; $display("FAIL burst_idle_state got %b exp 00", prb); end
        checks++; if (sb_adr !== 12'h0C0) begin errors++; $display("FAIL burst_rs_grant_adr got %h exp 0c0", sb_adr); end
        checks++; if (rs_stall !== 1'b0) begin errors++; $display("FAIL burst_rs_grant_stall got %b exp 0", rs_stall); end
        tick();
        rs_stb = 0; sb_ack = 1;
        settle();
        checks++; if ({rs_ack, ps_ack} !== 2'b10) begin errors++; $display("FAIL burst_rs_ack_final got %b exp 10", {rs_ack, ps_ack}); end
        last_ps = 0;
        go_idle();
    endtask

    task test_err;
        rs_cyc = 1; rs_stb = 1; rs_we = 0; rs_adr = 12'h0AB;
        tick();
        rs_stb = 0; sb_err = 1; sb_rdat = 16'h1234;
        settle();
        checks++; if (rs_err !== 1'b1) begin errors++; $display("FAIL err_rs got %b exp 1", rs_err); end
        checks++; if (ps_err !== 1'b0) begin errors++; $display("FAIL err_ps got %b exp 0", ps_err); end
        checks++; if (rs_rdat !== 16'h1234) begin errors++; $display("FAIL err_rs_dat got %h exp 1234", rs_rdat); end
        checks++; if (rs_ack !== 1'b0) begin errors++; $display("FAIL err_rs_ack got %b exp 0", rs_ack); end
        last_ps = 0;
        go_idle();
    endtask

    task test_arbitration;
        logic exp_ps;
        logic [11:0] exp_adr;
        for (int i = 0; i < 4; i++) begin
            ps_cyc = 1; ps_stb = 1; ps_adr = 12'(12'h300 + i);
            rs_cyc = 1; rs_stb = 1; rs_adr = 12'(12'h400 + i);
            settle();
`ifdef SARB_RR_EN
            exp_ps = !last_ps;
`else
            exp_ps = 1'b0;
`endif
            exp_adr = exp_ps ? ps_adr : rs_adr;
            checks++; if (sb_adr !== exp_adr) begin errors++; $display("FAIL arb_grant[%0d] got %h exp %h", i, sb_adr, exp_adr); end
            checks++; if ((exp_ps ? rs_stall : ps_stall) !== 1'b1) begin errors++; $display("FAIL arb_loser_stall[%0d] got 0 exp 1", i); end
            tick();
            if (exp_ps) ps_stb = 0; else rs_stb = 0;
            sb_ack = 1;
            settle();
            checks++; if ({ps_ack, rs_ack} !== {exp_ps, !exp_ps}) begin errors++; $display("FAIL arb_ack[%0d] got %b exp %b", i, {ps_ack, rs_ack}, {exp_ps, !exp_ps}); end
            tick();
            if (exp_ps) ps_cyc = 0; else rs_cyc = 0;
            sb_ack = 0;
            settle();
            checks++; if (sb_cyc !== 1'b0) begin errors++; $display("FAIL arb_gap[%0d] got %b exp 0", i, sb_cyc); end
            tick();
            last_ps = exp_ps;
        end
        go_idle();
    endtask

    task test_reset_mid;
        logic [11:0] exp_adr;
        ps_cyc = 1; ps_stb = 1; ps_we = 0; ps_adr = 12'h010;
        settle();
        checks++; if (sb_cyc !== 1'b1) begin errors++; $display("FAIL rmid_pre_cyc got %b exp 1", sb_cyc); end
        tick();
        ps_stb = 0; sync_rst_i = 1;
        settle();
        checks++; if (sb_cyc !== 1'b0) begin errors++; $display("FAIL rmid_drop_cyc got %b exp 0", sb_cyc); end
        tick();
        sync_rst_i = 0; ps_cyc = 0; sb_ack = 1;
        settle();
        checks++; if (prb !== 2'b00) begin errors++; $display("FAIL rmid_state got %b exp 00", prb); end
        checks++; if (sb_cyc !== 1'b0) begin errors++; $display("FAIL rmid_cyc got %b exp 0", sb_cyc); end
        checks++; if ({ps_ack, rs_ack} !== 2'b00) begin errors++; $display("FAIL rmid_late_ack got %b exp 00", {ps_ack, rs_ack}); end
        tick();
        sb_ack = 0;
        ps_cyc = 1; ps_stb = 1; ps_adr = 12'h515;
        rs_cyc = 1; rs_stb = 1; rs_adr = 12'h626;
        settle();
`ifdef SARB_RR_EN
        exp_adr = 12'h515;
`else
        exp_adr = 12'h626;
`endif
        checks++; if (sb_adr !== exp_adr) begin errors++; $display("FAIL rmid_tie_after_rst got %h exp %h", sb_adr, exp_adr); end
        go_idle();
    endtask

    initial begin
        sync_rst_i = 1;
        last_ps = 0;
        clear_inputs();
        test_reset();
        test_ps_write();
        test_burst();
        test_err();
        test_arbitration();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
